// File: rtl/friet_c_stream_pack_in.sv
// Packs byte-sized input words into wide output blocks; a message end pads the
// block with zero words, and a two-stage fill/output structure keeps one word per cycle.
module friet_c_stream_pack_in #(
    parameter int DIN_WIDTH       = 32,
    parameter int DIN_SIZE_WIDTH  = 2,
    parameter int DOUT_WIDTH      = 128,
    parameter int DOUT_SIZE_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_WIDTH-1:0]       din,
    input  logic [DIN_SIZE_WIDTH:0]    din_size,
    input  logic                       din_last,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DOUT_WIDTH-1:0]      dout,
    output logic [DOUT_SIZE_WIDTH:0]   dout_size,
    output logic                       dout_last,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [DOUT_SIZE_WIDTH-DIN_SIZE_WIDTH:0] fill_words,
    output logic                       out_occupied
);
    localparam int N  = DOUT_WIDTH / DIN_WIDTH;
    localparam int W  = DOUT_SIZE_WIDTH - DIN_SIZE_WIDTH;
    localparam int NB = DIN_WIDTH / 8;

    logic [DOUT_WIDTH-1:0]      fill_buf_reg, fill_buf_next;
    logic [DOUT_SIZE_WIDTH:0]   fill_bytes_reg, fill_bytes_next;
    logic [W:0]                 fill_words_reg, fill_words_next;
    logic                       fill_last_reg, fill_last_next;
    logic [DOUT_WIDTH-1:0]      out_buf_reg, out_buf_next;
    logic [DOUT_SIZE_WIDTH:0]   out_size_reg, out_size_next;
    logic                       out_last_reg, out_last_next;
    logic                       out_valid_reg, out_valid_next;

    logic [DIN_WIDTH-1:0]       din_masked;
    logic [DOUT_SIZE_WIDTH:0]   din_size_ext;
    logic                       fill_full, transfer, out_hs, in_hs;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign din_masked[8*gi +: 8] =
                (din_size > (DIN_SIZE_WIDTH+1)'(gi)) ? din[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign din_size_ext = {{W{1'b0}}, din_size};
    assign fill_full    = (fill_words_reg == (W+1)'(N));
    assign out_hs       = out_valid_reg & dout_ready;
    assign transfer     = fill_full & (~out_valid_reg | dout_ready);
    // Gated by rst so the handshake drops the instant reset is asserted.
    assign din_ready    = ~rst & ((~fill_last_reg & ~fill_full) | transfer);
    assign in_hs        = din_valid & din_ready;

    always_comb begin
        fill_buf_next   = fill_buf_reg;
        fill_bytes_next = fill_bytes_reg;
        fill_words_next = fill_words_reg;
        fill_last_next  = fill_last_reg;
        if (in_hs) begin
            if (transfer) begin
                // The accepted word starts the freshly cleared fill stage.
                fill_buf_next   = {din_masked, {(DOUT_WIDTH-DIN_WIDTH){1'b0}}};
                fill_words_next = (W+1)'(1);
                fill_bytes_next = din_size_ext;
            end else begin
                fill_buf_next   = {din_masked, fill_buf_reg[DOUT_WIDTH-1:DIN_WIDTH]};
                fill_words_next = fill_words_reg + (W+1)'(1);
                fill_bytes_next = fill_bytes_reg + din_size_ext;
            end
            fill_last_next = din_last;
        end else if (transfer) begin
            fill_buf_next   = '0;
            fill_bytes_next = '0;
            fill_words_next = '0;
            fill_last_next  = 1'b0;
        end else if (fill_last_reg && !fill_full) begin
            fill_buf_next   = {{DIN_WIDTH{1'b0}}, fill_buf_reg[DOUT_WIDTH-1:DIN_WIDTH]};
            fill_words_next = fill_words_reg + (W+1)'(1);
        end
    end

    always_comb begin
        out_buf_next   = out_buf_reg;
        out_size_next  = out_size_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        if (transfer) begin
            out_buf_next   = fill_buf_reg;
            out_size_next  = fill_bytes_reg;
            out_last_next  = fill_last_reg;
            out_valid_next = 1'b1;
        end else if (out_hs) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_buf_reg   <= '0;
            fill_bytes_reg <= '0;
            fill_words_reg <= '0;
            fill_last_reg  <= 1'b0;
            out_buf_reg    <= '0;
            out_size_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            fill_buf_reg   <= fill_buf_next;
            fill_bytes_reg <= fill_bytes_next;
            fill_words_reg <= fill_words_next;
            fill_last_reg  <= fill_last_next;
            out_buf_reg    <= out_buf_next;
            out_size_reg   <= out_size_next;
            out_last_reg   <= out_last_next;
            out_valid_reg  <= out_valid_next;
        end
    end

    assign dout         = out_buf_reg;
    assign dout_size    = out_size_reg;
    assign dout_last    = out_last_reg;
    assign dout_valid   = out_valid_reg;
    assign out_occupied = out_valid_reg;
    assign fill_words   = fill_words_reg;
endmodule
